// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents: receiver state enum, data width, baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated clock divider producing a one-cycle oversample tick every DIV cycles.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous reset, active-high
//   en    in   count enable; counter held at 0 while low
//   tick  out  one-cycle pulse when the counter wraps at DIV-1
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver presenting bytes as an 8-bit AXI-Stream master with a single holding register.
// tlast marks the terminator byte LAST_BYTE. Framing/overrun errors are one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
// Ports:
//   m_axis_aclk_i    in   clock
//   m_axis_arst_i    in   asynchronous reset, active-high
//   rx_i             in   asynchronous UART line, idle high
//   m_axis_tvalid_o  out  byte valid
//   m_axis_tdata_o   out  received byte
//   m_axis_tlast_o   out  tdata == LAST_BYTE
//   m_axis_tready_i  in   downstream ready
//   frame_err_o      out  pulse: stop bit sampled low
//   overrun_o        out  pulse: byte completed while holding register full
//   parity_err_o     out  pulse: parity mismatch (0 without UART_RX_PARITY_EN)
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter logic [7:0]  LAST_BYTE   = 8'h0D
) (
  input  logic       m_axis_aclk_i,
  input  logic       m_axis_arst_i,
  input  logic       rx_i,
  output logic       m_axis_tvalid_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tlast_o,
  input  logic       m_axis_tready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SampleMid = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SampleMax = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BitMax    = BW'(DATA_BITS - 1);

  logic rx_meta_q, rx_sync_q;

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tick, mid;
  logic                 deliver;
  logic                 frame_err_d;

  logic                 tvalid_q;
  logic [7:0]           tdata_q;
  logic                 tlast_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  // Two-flop synchroniser, reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge m_axis_aclk_i or posedge m_axis_arst_i) begin
    if (m_axis_arst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (m_axis_aclk_i),
    .rst  (m_axis_arst_i),
    .en   (state_q != StIdle),
    .tick (tick)
  );

  assign mid = tick && (sample_q == SampleMid);

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q, parity_bad_d;
  logic parity_err_d, parity_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    if (state_q == StIdle) begin
      sample_d = '0;
    end else if (tick) begin
      sample_d = (sample_q == SampleMax) ? '0 : sample_q + SW'(1);
    end

    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          parity_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        // Line back high by mid start bit: treat as a glitch.
        if (mid) state_d = rx_sync_q ? StIdle : StData;
      end
      StData: begin
        if (mid) begin
          shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BitMax) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (mid) begin
          // Even parity: data ones plus parity bit must be even.
          if (rx_sync_q != ^shreg_q) begin
            parity_err_d = 1'b1;
            parity_bad_d = 1'b1;
          end
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (mid) begin
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end else begin
`ifdef UART_RX_PARITY_EN
            deliver = !parity_bad_q;
`else
            deliver = 1'b1;
`endif
            state_d = StIdle;
          end
        end
      end
      StWaitHigh: begin
        // Break holds the line low; wait it out so it yields one error only.
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axis_aclk_i or posedge m_axis_arst_i) begin
    if (m_axis_arst_i) begin
      state_q  <= StIdle;
      sample_q <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Holding register. A new byte may load in the same cycle the held one is taken.
  always_ff @(posedge m_axis_aclk_i or posedge m_axis_arst_i) begin
    if (m_axis_arst_i) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= 1'b0;
      if (deliver) begin
        if (!tvalid_q || m_axis_tready_i) begin
          tvalid_q <= 1'b1;
          tdata_q  <= shreg_q;
          tlast_q  <= (shreg_q == LAST_BYTE);
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready_i) begin
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tlast_o  = tlast_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_o       = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o    = parity_err_q;
`else
  assign parity_err_o    = 1'b0;
`endif

endmodule
